// File: rtl/p_to_s_pingpong_converter_if.sv
// Frame-in / beat-out bundle for the ping-pong parallel-to-serial converter.
// The producer side drives ien/idata/fct; the converter drives the rest.
interface p_to_s_pingpong_converter_if #(
   parameter int unsigned PARALLEL_LENGTH = 32,
   parameter int unsigned SERIAL_LENGTH   = 1,
   parameter int unsigned DATA_WIDTH      = 32
);
   logic                                       ien;
   logic [0:PARALLEL_LENGTH-1][DATA_WIDTH-1:0] idata;
   logic                                       fct;
   logic                                       oen;
   logic [0:SERIAL_LENGTH-1][DATA_WIDTH-1:0]   odata;
   logic                                       olast;
   logic                                       full;

   modport master (
      output ien, idata, fct,
      input  oen, odata, olast, full
   );

   modport slave (
      input  ien, idata, fct,
      output oen, odata, olast, full
   );
endinterface

// File: rtl/p_to_s_pingpong_converter.sv
// Parallel-to-serial converter: two frame slots in ping-pong, frames drained as
// PARALLEL_LENGTH/SERIAL_LENGTH registered beats with a frame-end marker and hold.
module p_to_s_pingpong_converter #(
   parameter int unsigned PARALLEL_LENGTH = 32,
   parameter int unsigned SERIAL_LENGTH   = 1,
   parameter int unsigned DATA_WIDTH      = 32
) (
   input logic                        clk,
   input logic                        rst,
   p_to_s_pingpong_converter_if.slave bus
);

   localparam int unsigned BEATS = (SERIAL_LENGTH == 0) ? 1 : PARALLEL_LENGTH / SERIAL_LENGTH;
   localparam int unsigned CW    = (BEATS > 1) ? $clog2(BEATS) : 1;
   localparam int unsigned IW    = (PARALLEL_LENGTH > 1) ? $clog2(PARALLEL_LENGTH) : 1;
   localparam logic [CW-1:0] LAST_CNT = CW'(BEATS - 1);

   if (SERIAL_LENGTH == 0) begin : g_bad_serial
      $error("SERIAL_LENGTH must be at least 1");
   end else if (PARALLEL_LENGTH % SERIAL_LENGTH != 0) begin : g_bad_ratio
      $error("PARALLEL_LENGTH must be a multiple of SERIAL_LENGTH");
   end

   typedef logic [0:PARALLEL_LENGTH-1][DATA_WIDTH-1:0] frame_t;
   typedef logic [0:SERIAL_LENGTH-1][DATA_WIDTH-1:0]   beat_t;

   frame_t          slot_q [2];
   logic            wr_ptr_q;
   logic            rd_ptr_q;
   logic [1:0]      occ_q, occ_d;
   logic [CW-1:0]   cnt_q, cnt_d;
   logic            oen_q;
   logic            olast_q;
   beat_t           odata_q;

   logic            is_full;
   logic            accept;
   logic            emit;
   logic            last_beat;
   logic            release_slot;
   beat_t           beat;

   always_comb begin
      is_full      = (occ_q == 2'd2);
      accept       = bus.ien & ~is_full;
      emit         = (occ_q != 2'd0) & ~bus.fct;
      last_beat    = (cnt_q == LAST_CNT);
      release_slot = emit & last_beat;
      // Accept and release together leave the count unchanged.
      occ_d        = occ_q + {1'b0, accept} - {1'b0, release_slot};

      cnt_d = cnt_q;
      if (emit) begin
         cnt_d = last_beat ? '0 : cnt_q + CW'(1);
      end

      beat = '0;
      for (int unsigned i = 0; i < SERIAL_LENGTH; i++) begin
         beat[i] = slot_q[rd_ptr_q][IW'(32'(cnt_q) * SERIAL_LENGTH + i)];
      end
   end

   // Slot contents need no reset: nothing reads a slot that occ does not count.
   always_ff @(posedge clk) begin
      if (accept) begin
         slot_q[wr_ptr_q] <= bus.idata;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         occ_q    <= 2'd0;
         wr_ptr_q <= 1'b0;
         rd_ptr_q <= 1'b0;
         cnt_q    <= '0;
         oen_q    <= 1'b0;
         olast_q  <= 1'b0;
         odata_q  <= '0;
      end else begin
         occ_q   <= occ_d;
         cnt_q   <= cnt_d;
         oen_q   <= emit;
         olast_q <= release_slot;
         if (accept) begin
            wr_ptr_q <= ~wr_ptr_q;
         end
         if (release_slot) begin
            rd_ptr_q <= ~rd_ptr_q;
         end
         if (emit) begin
            odata_q <= beat;
         end
      end
   end

   assign bus.oen   = oen_q;
   assign bus.olast = olast_q;
   assign bus.odata = odata_q;
   assign bus.full  = is_full;

endmodule

// File: tb/tb_p_to_s_pingpong_converter.sv
// Bench for the ping-pong converter: an 8/2 instance and a 4/4 instance checked
// every cycle against a frame-queue model, directed scenarios then random traffic.
module tb_p_to_s_pingpong_converter;

   localparam int unsigned PA = 8;
   localparam int unsigned SA = 2;
   localparam int unsigned PB = 4;
   localparam int unsigned SB = 4;
   localparam int unsigned W  = 32;

   typedef logic [0:PA-1][W-1:0] frame_a_t;
   typedef logic [0:SA-1][W-1:0] beat_a_t;
   typedef logic [0:PB-1][W-1:0] frame_b_t;
   typedef logic [0:SB-1][W-1:0] beat_b_t;

   logic clk;
   logic rst;

   p_to_s_pingpong_converter_if #(
      .PARALLEL_LENGTH(PA), .SERIAL_LENGTH(SA), .DATA_WIDTH(W)
   ) bus_a ();
   p_to_s_pingpong_converter_if #(
      .PARALLEL_LENGTH(PB), .SERIAL_LENGTH(SB), .DATA_WIDTH(W)
   ) bus_b ();

   p_to_s_pingpong_converter #(
      .PARALLEL_LENGTH(PA), .SERIAL_LENGTH(SA), .DATA_WIDTH(W)
   ) u_dut_a (
      .clk(clk),
      .rst(rst),
      .bus(bus_a)
   );

   p_to_s_pingpong_converter #(
      .PARALLEL_LENGTH(PB), .SERIAL_LENGTH(SB), .DATA_WIDTH(W)
   ) u_dut_b (
      .clk(clk),
      .rst(rst),
      .bus(bus_b)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_cmp  = 0;
   int n_fail = 0;

   // Model: queue of stored frames (head is the one draining) plus beat position.
   frame_a_t qa[$];
   int       pos_a = 0;
   logic     ea_oen = 1'b0;
   logic     ea_olast = 1'b0;
   beat_a_t  ea_odata = '0;

   frame_b_t qb[$];
   int       pos_b = 0;
   logic     eb_oen = 1'b0;
   logic     eb_olast = 1'b0;
   beat_b_t  eb_odata = '0;

   task automatic model_a();
      bit was_full;
      was_full = (qa.size() == 2);
      if (rst) begin
         qa.delete();
         pos_a    = 0;
         ea_oen   = 1'b0;
         ea_olast = 1'b0;
         ea_odata = '0;
      end else begin
         if (qa.size() != 0 && !bus_a.fct) begin
            for (int i = 0; i < int'(SA); i++) ea_odata[i] = qa[0][pos_a * int'(SA) + i];
            ea_oen   = 1'b1;
            ea_olast = (pos_a == int'(PA / SA) - 1);
            if (ea_olast) begin
               void'(qa.pop_front());
               pos_a = 0;
            end else begin
               pos_a++;
            end
         end else begin
            ea_oen   = 1'b0;
            ea_olast = 1'b0;
         end
         if (bus_a.ien && !was_full) qa.push_back(bus_a.idata);
      end
   endtask

   task automatic model_b();
      bit was_full;
      was_full = (qb.size() == 2);
      if (rst) begin
         qb.delete();
         pos_b    = 0;
         eb_oen   = 1'b0;
         eb_olast = 1'b0;
         eb_odata = '0;
      end else begin
         if (qb.size() != 0 && !bus_b.fct) begin
            for (int i = 0; i < int'(SB); i++) eb_odata[i] = qb[0][pos_b * int'(SB) + i];
            eb_oen   = 1'b1;
            eb_olast = (pos_b == int'(PB / SB) - 1);
            if (eb_olast) begin
               void'(qb.pop_front());
               pos_b = 0;
            end else begin
               pos_b++;
            end
         end else begin
            eb_oen   = 1'b0;
            eb_olast = 1'b0;
         end
         if (bus_b.ien && !was_full) qb.push_back(bus_b.idata);
      end
   endtask

   task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h at %0t", tag, obs, exp, $time);
      end
   endtask

   task automatic cycle();
      @(posedge clk);
      model_a();
      model_b();
      #1;
      chk("a_oen",   128'(bus_a.oen),   128'(ea_oen));
      chk("a_olast", 128'(bus_a.olast), 128'(ea_olast));
      chk("a_odata", 128'(bus_a.odata), 128'(ea_odata));
      chk("a_full",  128'(bus_a.full),  128'(qa.size() == 2));
      chk("b_oen",   128'(bus_b.oen),   128'(eb_oen));
      chk("b_olast", 128'(bus_b.olast), 128'(eb_olast));
      chk("b_odata", 128'(bus_b.odata), 128'(eb_odata));
      chk("b_full",  128'(bus_b.full),  128'(qb.size() == 2));
   endtask

   function automatic frame_a_t seq_a(input int base);
      frame_a_t f;
      for (int i = 0; i < int'(PA); i++) f[i] = W'(base + i);
      return f;
   endfunction

   function automatic frame_b_t seq_b(input int base);
      frame_b_t f;
      for (int i = 0; i < int'(PB); i++) f[i] = W'(base + i);
      return f;
   endfunction

   task automatic drive_a(input bit ien, input frame_a_t f, input bit fct);
      bus_a.ien   = ien;
      bus_a.idata = f;
      bus_a.fct   = fct;
   endtask

   task automatic drive_b(input bit ien, input frame_b_t f, input bit fct);
      bus_b.ien   = ien;
      bus_b.idata = f;
      bus_b.fct   = fct;
   endtask

   initial begin
      frame_a_t ra;
      frame_b_t rb;

      rst = 1'b1;
      drive_a(1'b0, '0, 1'b0);
      drive_b(1'b0, '0, 1'b0);
      repeat (2) cycle();
      rst = 1'b0;
      cycle();

      // Single frame 0..7, no hold.
      drive_a(1'b1, seq_a(0), 1'b0);
      cycle();
      drive_a(1'b0, '0, 1'b0);
      repeat (6) cycle();

      // Two frames back to back stream without a bubble.
      drive_a(1'b1, seq_a(10), 1'b0);
      cycle();
      drive_a(1'b1, seq_a(20), 1'b0);
      cycle();
      drive_a(1'b0, '0, 1'b0);
      repeat (10) cycle();

      // Three frames under hold: third is dropped while full.
      drive_a(1'b1, seq_a(30), 1'b1);
      cycle();
      drive_a(1'b1, seq_a(40), 1'b1);
      cycle();
      drive_a(1'b1, seq_a(50), 1'b1);
      cycle();
      drive_a(1'b0, '0, 1'b1);
      repeat (3) cycle();
      drive_a(1'b0, '0, 1'b0);
      repeat (10) cycle();

      // Hold toggling every cycle during a frame.
      drive_a(1'b1, seq_a(60), 1'b0);
      cycle();
      for (int i = 0; i < 12; i++) begin
         drive_a(1'b0, '0, (i % 2) == 0);
         cycle();
      end
      drive_a(1'b0, '0, 1'b0);
      repeat (4) cycle();

      // Single-beat frames every cycle on the 4/4 instance.
      for (int i = 0; i < 6; i++) begin
         drive_b(1'b1, seq_b(100 + 4 * i), 1'b0);
         cycle();
      end
      drive_b(1'b0, '0, 1'b0);
      repeat (2) cycle();

      // Reset on the second beat, then a fresh frame starts at element 0.
      drive_a(1'b1, seq_a(70), 1'b0);
      cycle();
      drive_a(1'b0, '0, 1'b0);
      cycle();
      rst = 1'b1;
      cycle();
      rst = 1'b0;
      cycle();
      drive_a(1'b1, seq_a(80), 1'b0);
      cycle();
      drive_a(1'b0, '0, 1'b0);
      repeat (5) cycle();

      // Random traffic on both instances with occasional reset.
      for (int n = 0; n < 600; n++) begin
         for (int i = 0; i < int'(PA); i++) ra[i] = $urandom;
         for (int i = 0; i < int'(PB); i++) rb[i] = $urandom;
         rst = ($urandom_range(0, 79) == 0);
         drive_a($urandom_range(0, 3) == 0, ra, $urandom_range(0, 3) == 0);
         drive_b($urandom_range(0, 2) != 0, rb, $urandom_range(0, 2) == 0);
         cycle();
      end
      rst = 1'b0;
      drive_a(1'b0, '0, 1'b0);
      drive_b(1'b0, '0, 1'b0);
      repeat (12) cycle();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
